// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// default bus widths, reset PC and reset level.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
  localparam logic        RST_ENABLE = 1'b1;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus: request/address out, address-accept and
// read-data handshake back.
interface inst_fetch_ctrl_if
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_rdata, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_rdata, inst_data_ok
  );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_watchdog.sv
// Fetch bus watchdog: counts cycles spent in WAIT/DISCARD and raises a sticky
// bus error on a WAIT timeout. Only built when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  state_e            state,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              data_ok,
  output logic              expired_c,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_eff;
  logic [ADDR_W-1:0] pc_prev_q;
  logic              run;
  logic              entered;

  // Count restarts on every state entry, so the first cycle in a state sees 0.
  assign run       = (state == WAIT) || (state == DISCARD);
  assign entered   = (state != state_prev_q);
  assign cnt_eff   = entered ? '0 : cnt_q;
  assign expired_c = run && (cnt_eff == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_prev_q <= IDLE;
      cnt_q        <= '0;
      pc_prev_q    <= '0;
      err          <= 1'b0;
    end else begin
      state_prev_q <= state;
      pc_prev_q    <= pc_i;
      cnt_q        <= run ? cnt_eff + CNT_W'(1) : '0;
      if (flush_i || (pc_i != pc_prev_q)) begin
        err <= 1'b0;
      end else if (expired_c && (state == WAIT) && !data_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: one bus read per PC, single-entry word buffer,
// stale-response discard on flush. Optional bus watchdog: FETCH_TIMEOUT_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               flush_i,
  inst_fetch_ctrl_if.master  bus,
  output logic [DATA_W-1:0]  inst_o,
  output logic               inst_valid_o,
  output logic               exc_adel_o,
  output logic               exc_ibe_o,
  output logic               stall_req_o
);

  state_e            state_q;
  logic              inst_req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              drop_q;
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_inst_q;
  logic              hit;
  logic              misaligned;
  logic              wd_expired_c;

  assign hit          = buf_valid_q && (buf_addr_q == pc_i);
  assign misaligned   = (pc_i[1:0] != 2'b00);
  assign inst_o       = hit ? buf_inst_q : '0;
  assign exc_adel_o   = misaligned;
  assign inst_valid_o = hit || misaligned || exc_ibe_o;
  assign stall_req_o  = !inst_valid_o;

  assign bus.inst_req  = inst_req_q;
  assign bus.inst_addr = req_addr_q;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .state     (state_q),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .data_ok   (bus.inst_data_ok),
    .expired_c (wd_expired_c),
    .err       (exc_ibe_o)
  );
`else
  logic unused_cfg;
  assign unused_cfg   = ^{32'(TIMEOUT)};
  assign wd_expired_c = 1'b0;
  assign exc_ibe_o    = 1'b0;
`endif

  // Fetch FSM; the request stays up until accepted, then at most one read is outstanding.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= IDLE;
      inst_req_q  <= 1'b0;
      req_addr_q  <= '0;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_inst_q  <= '0;
    end else begin
      if (flush_i) begin
        buf_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (!hit && !misaligned && !flush_i) begin
            req_addr_q <= pc_i;
            inst_req_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (flush_i) begin
            drop_q <= 1'b1;
          end
          if (bus.inst_addr_ok) begin
            inst_req_q <= 1'b0;
            drop_q     <= 1'b0;
            state_q    <= (drop_q || flush_i) ? DISCARD : WAIT;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            // Only keep the word if it still belongs to the current PC.
            if (!flush_i && (req_addr_q == pc_i)) begin
              buf_inst_q  <= bus.inst_rdata;
              buf_addr_q  <= req_addr_q;
              buf_valid_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (flush_i) begin
            state_q <= DISCARD;
          end else if (wd_expired_c) begin
            state_q <= IDLE;
          end
        end
        DISCARD: begin
          if (bus.inst_data_ok || wd_expired_c) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: table of per-cycle vectors followed by
// hand-written flush, sticky-drop and timeout sequences.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam logic [31:0] A0   = RESET_PC;
  localparam logic [31:0] A2   = 32'hbfc0_0002;
  localparam logic [31:0] A4   = 32'hbfc0_0004;
  localparam logic [31:0] A10  = 32'hbfc0_0010;
  localparam logic [31:0] A20  = 32'hbfc0_0020;
  localparam logic [31:0] A24  = 32'hbfc0_0024;
  localparam logic [31:0] A380 = 32'hbfc0_0380;
  localparam logic [31:0] Z    = 32'h0;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exc_adel;
  logic        exc_ibe;
  logic        stall_req;

  int checks;
  int errors;

  inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .flush_i      (flush),
    .bus          (bus.master),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .exc_adel_o   (exc_adel),
    .exc_ibe_o    (exc_ibe),
    .stall_req_o  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic        adel;
    logic        stall;
  } vec_t;

  vec_t vt [17];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic f, input logic aok,
                       input logic dok, input logic [31:0] rd);
    pc                = p;
    flush             = f;
    bus.inst_addr_ok  = aok;
    bus.inst_data_ok  = dok;
    bus.inst_rdata    = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(A0, 1'b0, 1'b0, 1'b0, Z);

    // Per-cycle vectors: pc, flush, aok, dok, rdata | req, addr, valid, inst, adel, stall
    vt[0]  = '{A0,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b0, Z,             1'b0, 1'b1};
    vt[1]  = '{A0,  1'b0, 1'b1, 1'b0, Z,             1'b1, A0, 1'b0, Z,             1'b0, 1'b1};
    vt[2]  = '{A0,  1'b0, 1'b0, 1'b1, 32'h24080001,  1'b0, Z,  1'b0, Z,             1'b0, 1'b1};
    vt[3]  = '{A0,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b1, 32'h24080001,  1'b0, 1'b0};
    vt[4]  = '{A0,  1'b0, 1'b0, 1'b1, 32'hffffffff,  1'b0, Z,  1'b1, 32'h24080001,  1'b0, 1'b0};
    vt[5]  = '{A2,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b1, Z,             1'b1, 1'b0};
    vt[6]  = '{A2,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b1, Z,             1'b1, 1'b0};
    vt[7]  = '{A0,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b1, 32'h24080001,  1'b0, 1'b0};
    vt[8]  = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b0, Z,             1'b0, 1'b1};
    vt[9]  = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b1, A4, 1'b0, Z,             1'b0, 1'b1};
    vt[10] = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b1, A4, 1'b0, Z,             1'b0, 1'b1};
    vt[11] = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b1, A4, 1'b0, Z,             1'b0, 1'b1};
    vt[12] = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b1, A4, 1'b0, Z,             1'b0, 1'b1};
    vt[13] = '{A4,  1'b0, 1'b1, 1'b0, Z,             1'b1, A4, 1'b0, Z,             1'b0, 1'b1};
    vt[14] = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b0, Z,             1'b0, 1'b1};
    vt[15] = '{A4,  1'b0, 1'b0, 1'b1, 32'h11112222,  1'b0, Z,  1'b0, Z,             1'b0, 1'b1};
    vt[16] = '{A4,  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,  1'b1, 32'h11112222,  1'b0, 1'b0};

    // Reset state
    step();
    step();
    #1;
    chk_b("rst_req", bus.inst_req, 1'b0);
    chk_w("rst_addr", bus.inst_addr, Z);
    chk_b("rst_valid", inst_valid, 1'b0);
    chk_w("rst_inst", inst, Z);
    chk_b("rst_ibe", exc_ibe, 1'b0);
    chk_b("rst_stall", stall_req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic fetch, idle data_ok, misaligned PC, delayed addr_ok
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].pc, vt[i].flush, vt[i].aok, vt[i].dok, vt[i].rdata);
      #1;
      chk_b($sformatf("v%0d_req", i), bus.inst_req, vt[i].req);
      if (vt[i].req) chk_w($sformatf("v%0d_addr", i), bus.inst_addr, vt[i].addr);
      chk_b($sformatf("v%0d_valid", i), inst_valid, vt[i].valid);
      chk_w($sformatf("v%0d_inst", i), inst, vt[i].inst);
      chk_b($sformatf("v%0d_adel", i), exc_adel, vt[i].adel);
      chk_b($sformatf("v%0d_stall", i), stall_req, vt[i].stall);
      chk_b($sformatf("v%0d_ibe", i), exc_ibe, 1'b0);
      step();
    end

    // Flush while waiting for data: stale word must be dropped
    drive(A0, 1'b0, 1'b0, 1'b0, Z);          #1; chk_b("fw_miss", inst_valid, 1'b0); step();
    drive(A0, 1'b0, 1'b1, 1'b0, Z);          #1; chk_w("fw_addr", bus.inst_addr, A0); step();
    drive(A380, 1'b1, 1'b0, 1'b0, Z);        #1; chk_b("fw_flush_valid", inst_valid, 1'b0); step();
    drive(A380, 1'b0, 1'b0, 1'b1, 32'hdeadbeef); #1; chk_w("fw_stale_inst", inst, Z); step();
    drive(A380, 1'b0, 1'b0, 1'b0, Z);        #1; chk_b("fw_after_drop", inst_valid, 1'b0);
    chk_w("fw_no_dead", inst, Z); step();
    drive(A380, 1'b0, 1'b1, 1'b0, Z);        #1; chk_b("fw_refetch_req", bus.inst_req, 1'b1);
    chk_w("fw_refetch_addr", bus.inst_addr, A380); step();
    drive(A380, 1'b0, 1'b0, 1'b1, 32'h3c1a0000); #1; step();
    drive(A380, 1'b0, 1'b0, 1'b0, Z);        #1; chk_w("fw_new_inst", inst, 32'h3c1a0000);
    chk_b("fw_new_valid", inst_valid, 1'b1);

    // Flush coincident with data_ok: flush wins, refetch next cycle
    drive(A10, 1'b0, 1'b0, 1'b0, Z);         #1; step();
    drive(A10, 1'b0, 1'b1, 1'b0, Z);         #1; chk_w("fd_addr", bus.inst_addr, A10); step();
    drive(A10, 1'b1, 1'b0, 1'b1, 32'haaaa5555); #1; step();
    drive(A10, 1'b0, 1'b0, 1'b0, Z);         #1; chk_b("fd_no_valid", inst_valid, 1'b0);
    chk_w("fd_no_old", inst, Z); step();
    drive(A10, 1'b0, 1'b1, 1'b0, Z);         #1; chk_b("fd_refetch_req", bus.inst_req, 1'b1);
    chk_w("fd_refetch_addr", bus.inst_addr, A10); step();
    drive(A10, 1'b0, 1'b0, 1'b1, 32'h12345678); #1; step();
    drive(A10, 1'b0, 1'b0, 1'b0, Z);         #1; chk_w("fd_new_inst", inst, 32'h12345678);

    // Flush in IDLE invalidates the buffer and blocks a new request that cycle
    drive(A10, 1'b1, 1'b0, 1'b0, Z);         #1; step();
    drive(A10, 1'b0, 1'b0, 1'b0, Z);         #1; chk_b("fi_valid", inst_valid, 1'b0);
    chk_b("fi_req", bus.inst_req, 1'b0); step();
    drive(A10, 1'b0, 1'b1, 1'b0, Z);         #1; chk_b("fi_req2", bus.inst_req, 1'b1); step();
    drive(A10, 1'b0, 1'b0, 1'b1, 32'h12345678); #1; step();

    // Flush during REQ: request held, response discarded after accept
    drive(A20, 1'b0, 1'b0, 1'b0, Z);         #1; step();
    drive(A20, 1'b1, 1'b0, 1'b0, Z);         #1; chk_b("fr_req_held", bus.inst_req, 1'b1); step();
    drive(A20, 1'b0, 1'b1, 1'b0, Z);         #1; chk_w("fr_addr_held", bus.inst_addr, A20); step();
    drive(A20, 1'b0, 1'b0, 1'b1, 32'h55555555); #1; step();
    drive(A20, 1'b0, 1'b0, 1'b0, Z);         #1; chk_b("fr_dropped", inst_valid, 1'b0);
    chk_w("fr_inst", inst, Z); step();

    // No data after accept: watchdog or indefinite stall
    drive(A20, 1'b0, 1'b1, 1'b0, Z);         #1; chk_b("to_req", bus.inst_req, 1'b1); step();
    for (int i = 0; i < 8; i++) begin
      drive(A20, 1'b0, 1'b0, 1'b0, Z);
      #1;
      chk_b($sformatf("to_wait%0d_stall", i), stall_req, 1'b1);
      chk_b($sformatf("to_wait%0d_ibe", i), exc_ibe, 1'b0);
      step();
    end
`ifdef FETCH_TIMEOUT_EN
    chk_b("to_ibe", exc_ibe, 1'b1);
    chk_b("to_stall", stall_req, 1'b0);
    chk_b("to_valid", inst_valid, 1'b1);
    chk_w("to_inst", inst, Z);
    drive(A24, 1'b0, 1'b0, 1'b0, Z);
    step();
    chk_b("to_ibe_clr", exc_ibe, 1'b0);
`else
    begin
      int drops;
      drops = 0;
      for (int i = 0; i < 300; i++) begin
        if (stall_req !== 1'b1) drops++;
        step();
      end
      chk_w("to_stall_drops", 32'(drops), Z);
      chk_b("to_stall_end", stall_req, 1'b1);
      chk_b("to_ibe_off", exc_ibe, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
